// File: rtl/amt_recovery_walker_if.sv
// AMT-to-RMT recovery walker bus bundle.
// Carries the start request, AMT read ports, RMT write ports and status.
interface amt_recovery_walker_if #(
  parameter int SRAM_INDEX = 4,
  parameter int SRAM_WIDTH = 8
);
  logic                  recover_i;
  logic [SRAM_INDEX-1:0] amt_addr0_o;
  logic [SRAM_INDEX-1:0] amt_addr1_o;
  logic [SRAM_INDEX-1:0] amt_addr2_o;
  logic [SRAM_INDEX-1:0] amt_addr3_o;
  logic [SRAM_WIDTH-1:0] amt_data0_i;
  logic [SRAM_WIDTH-1:0] amt_data1_i;
  logic [SRAM_WIDTH-1:0] amt_data2_i;
  logic [SRAM_WIDTH-1:0] amt_data3_i;
  logic [SRAM_INDEX-1:0] rmt_addr0_o;
  logic [SRAM_INDEX-1:0] rmt_addr1_o;
  logic [SRAM_INDEX-1:0] rmt_addr2_o;
  logic [SRAM_INDEX-1:0] rmt_addr3_o;
  logic [SRAM_WIDTH-1:0] rmt_data0_o;
  logic [SRAM_WIDTH-1:0] rmt_data1_o;
  logic [SRAM_WIDTH-1:0] rmt_data2_o;
  logic [SRAM_WIDTH-1:0] rmt_data3_o;
  logic                  rmt_we0_o;
  logic                  rmt_we1_o;
  logic                  rmt_we2_o;
  logic                  rmt_we3_o;
  logic                  busy_o;
  logic                  done_o;

  modport master (
    input  recover_i,
    input  amt_data0_i, amt_data1_i,
    input  amt_data2_i, amt_data3_i,
    output amt_addr0_o, amt_addr1_o,
    output amt_addr2_o, amt_addr3_o,
    output rmt_addr0_o, rmt_addr1_o,
    output rmt_addr2_o, rmt_addr3_o,
    output rmt_data0_o, rmt_data1_o,
    output rmt_data2_o, rmt_data3_o,
    output rmt_we0_o, rmt_we1_o,
    output rmt_we2_o, rmt_we3_o,
    output busy_o, done_o
  );

  modport slave (
    output recover_i,
    output amt_data0_i, amt_data1_i,
    output amt_data2_i, amt_data3_i,
    input  amt_addr0_o, amt_addr1_o,
    input  amt_addr2_o, amt_addr3_o,
    input  rmt_addr0_o, rmt_addr1_o,
    input  rmt_addr2_o, rmt_addr3_o,
    input  rmt_data0_o, rmt_data1_o,
    input  rmt_data2_o, rmt_data3_o,
    input  rmt_we0_o, rmt_we1_o,
    input  rmt_we2_o, rmt_we3_o,
    input  busy_o, done_o
  );
endinterface

// File: rtl/amt_recovery_walker.sv
// Copies the AMT into the RMT after a flush, four entries per cycle.
// Reads in WALK, writes one cycle later; DRAIN flushes the last group.
module amt_recovery_walker #(
  parameter int SRAM_DEPTH = 16,
  parameter int SRAM_INDEX = 4,
  parameter int SRAM_WIDTH = 8
) (
  input logic clk,
  input logic reset,
  amt_recovery_walker_if.master bus
);
  localparam int GRPS = SRAM_DEPTH / 4;
  localparam int GW = (SRAM_INDEX > 2) ? SRAM_INDEX - 2 : 1;

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    DRAIN
  } state_e;

  state_e                state_q;
  logic [GW-1:0]         grp_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic [SRAM_INDEX-1:0] waddr_q [4];
  logic [SRAM_WIDTH-1:0] wdata_q [4];
  logic [SRAM_INDEX-1:0] rd_addr [4];
  logic [SRAM_WIDTH-1:0] rd_data [4];
  logic                  last;

  // grp_q sits at 0 outside WALK, so IDLE reads addresses 0..3
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rd_addr[k] = SRAM_INDEX'({grp_q, 2'(k)});
    end
  end

  assign rd_data[0] = bus.amt_data0_i;
  assign rd_data[1] = bus.amt_data1_i;
  assign rd_data[2] = bus.amt_data2_i;
  assign rd_data[3] = bus.amt_data3_i;
  assign last = (grp_q == GW'(GRPS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grp_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        waddr_q[k] <= '0;
        wdata_q[k] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          done_q  <= 1'b0;
          grp_q   <= '0;
          if (bus.recover_i) begin
            state_q <= WALK;
            busy_q  <= 1'b1;
          end
        end
        WALK: begin
          valid_q <= 1'b1;
          for (int k = 0; k < 4; k++) begin
            waddr_q[k] <= rd_addr[k];
            wdata_q[k] <= rd_data[k];
          end
          if (last) begin
            state_q <= DRAIN;
            done_q  <= 1'b1;
            grp_q   <= '0;
          end else begin
            grp_q <= grp_q + GW'(1);
          end
        end
        DRAIN: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.amt_addr0_o = rd_addr[0];
  assign bus.amt_addr1_o = rd_addr[1];
  assign bus.amt_addr2_o = rd_addr[2];
  assign bus.amt_addr3_o = rd_addr[3];
  assign bus.rmt_addr0_o = waddr_q[0];
  assign bus.rmt_addr1_o = waddr_q[1];
  assign bus.rmt_addr2_o = waddr_q[2];
  assign bus.rmt_addr3_o = waddr_q[3];
  assign bus.rmt_data0_o = wdata_q[0];
  assign bus.rmt_data1_o = wdata_q[1];
  assign bus.rmt_data2_o = wdata_q[2];
  assign bus.rmt_data3_o = wdata_q[3];
  assign bus.rmt_we0_o   = valid_q;
  assign bus.rmt_we1_o   = valid_q;
  assign bus.rmt_we2_o   = valid_q;
  assign bus.rmt_we3_o   = valid_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
endmodule
